// File: rtl/nonce_search_ctrl.sv
// Nonce sweep controller: issues nonces to the hash core, compares each hash MSB slice to a target
// and finishes after the requested number of hits or when the nonce space runs out.
`timescale 1ns/1ps

module nonce_search_ctrl #(
    parameter int unsigned         NONCE_W   = 32,
    parameter int unsigned         HASH_W    = 24,
    parameter int unsigned         TARGET_W  = 8,
    parameter logic [NONCE_W-1:0]  MAX_NONCE = {NONCE_W{1'b1}}
) (
    input  logic                clk,
    input  logic                reset_L,
    input  logic                start,
    input  logic [TARGET_W-1:0] target,
    input  logic [1:0]          num_entradas,
    output logic                hash_req,
    output logic [NONCE_W-1:0]  hash_nonce,
    input  logic                hash_valid,
    input  logic [HASH_W-1:0]   hash_in,
    output logic                fin,
    output logic                exhausted,
    output logic [NONCE_W-1:0]  nonce_valido_out,
    output logic [HASH_W-1:0]   bounty_out,
    output logic [2:0]          hit_count
);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StCheck,
        StDone
    } state_e;

    state_e                state_q, state_d;
    logic [NONCE_W-1:0]    nonce_q, nonce_d;
    logic [TARGET_W-1:0]   target_q, target_d;
    logic [2:0]            need_q, need_d;
    logic [HASH_W-1:0]     hash_q, hash_d;
    logic                  hash_req_q, hash_req_d;
    logic [NONCE_W-1:0]    hash_nonce_q, hash_nonce_d;
    logic                  fin_q, fin_d;
    logic                  exhausted_q, exhausted_d;
    logic [NONCE_W-1:0]    nonce_valido_q, nonce_valido_d;
    logic [HASH_W-1:0]     bounty_q, bounty_d;
    logic [2:0]            hit_count_q, hit_count_d;

    logic                  hit;
    logic [2:0]            hit_count_inc;
    logic [NONCE_W-1:0]    nonce_next;

    assign hit           = hash_q[HASH_W-1 -: TARGET_W] < target_q;
    assign hit_count_inc = hit_count_q + 3'd1;
    assign nonce_next    = nonce_q + NONCE_W'(1);

    always_comb begin
        state_d        = state_q;
        nonce_d        = nonce_q;
        target_d       = target_q;
        need_d         = need_q;
        hash_d         = hash_q;
        hash_req_d     = 1'b0;
        hash_nonce_d   = hash_nonce_q;
        fin_d          = fin_q;
        exhausted_d    = exhausted_q;
        nonce_valido_d = nonce_valido_q;
        bounty_d       = bounty_q;
        hit_count_d    = hit_count_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    target_d     = target;
                    need_d       = (num_entradas == 2'd0) ? 3'd4 : {1'b0, num_entradas};
                    nonce_d      = '0;
                    hit_count_d  = '0;
                    fin_d        = 1'b0;
                    exhausted_d  = 1'b0;
                    // Request is registered, so it is raised on entry to ISSUE.
                    hash_req_d   = 1'b1;
                    hash_nonce_d = '0;
                    state_d      = StIssue;
                end
            end
            StIssue: begin
                state_d = StWait;
            end
            StWait: begin
                if (hash_valid) begin
                    hash_d  = hash_in;
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (hit) begin
                    nonce_valido_d = nonce_q;
                    bounty_d       = hash_q;
                    hit_count_d    = hit_count_inc;
                end
                // A final hit on MAX_NONCE counts as success, not exhaustion.
                if (hit && (hit_count_inc == need_q)) begin
                    fin_d       = 1'b1;
                    exhausted_d = 1'b0;
                    state_d     = StDone;
                end else if (nonce_q == MAX_NONCE) begin
                    fin_d       = 1'b1;
                    exhausted_d = 1'b1;
                    state_d     = StDone;
                end else begin
                    nonce_d      = nonce_next;
                    hash_req_d   = 1'b1;
                    hash_nonce_d = nonce_next;
                    state_d      = StIssue;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q        <= StIdle;
            nonce_q        <= '0;
            target_q       <= '0;
            need_q         <= '0;
            hash_q         <= '0;
            hash_req_q     <= 1'b0;
            hash_nonce_q   <= '0;
            fin_q          <= 1'b0;
            exhausted_q    <= 1'b0;
            nonce_valido_q <= '0;
            bounty_q       <= '0;
            hit_count_q    <= '0;
        end else begin
            state_q        <= state_d;
            nonce_q        <= nonce_d;
            target_q       <= target_d;
            need_q         <= need_d;
            hash_q         <= hash_d;
            hash_req_q     <= hash_req_d;
            hash_nonce_q   <= hash_nonce_d;
            fin_q          <= fin_d;
            exhausted_q    <= exhausted_d;
            nonce_valido_q <= nonce_valido_d;
            bounty_q       <= bounty_d;
            hit_count_q    <= hit_count_d;
        end
    end

    assign hash_req         = hash_req_q;
    assign hash_nonce       = hash_nonce_q;
    assign fin              = fin_q;
    assign exhausted        = exhausted_q;
    assign nonce_valido_out = nonce_valido_q;
    assign bounty_out       = bounty_q;
    assign hit_count        = hit_count_q;

endmodule

// File: tb/tb_nonce_search_ctrl.sv
// Bench for nonce_search_ctrl: two instances (full nonce space and MAX_NONCE=15), each with a
// 3-cycle hash model; expected search results are queued at start and checked at fin.
`timescale 1ns/1ps

module tb_nonce_search_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_L;
    logic       start_a, start_b;
    logic [7:0] target;
    logic [1:0] num_entradas;

    logic        hash_req_a, hash_req_b;
    logic [31:0] hash_nonce_a, hash_nonce_b;
    logic        hash_valid_a, hash_valid_b;
    logic [23:0] hash_in_a, hash_in_b;
    logic        fin_a, fin_b;
    logic        exhausted_a, exhausted_b;
    logic [31:0] nv_a, nv_b;
    logic [23:0] bounty_a, bounty_b;
    logic [2:0]  hits_a, hits_b;

    nonce_search_ctrl dut_a (
        .clk              (clk),
        .reset_L          (reset_L),
        .start            (start_a),
        .target           (target),
        .num_entradas     (num_entradas),
        .hash_req         (hash_req_a),
        .hash_nonce       (hash_nonce_a),
        .hash_valid       (hash_valid_a),
        .hash_in          (hash_in_a),
        .fin              (fin_a),
        .exhausted        (exhausted_a),
        .nonce_valido_out (nv_a),
        .bounty_out       (bounty_a),
        .hit_count        (hits_a)
    );

    nonce_search_ctrl #(.MAX_NONCE(32'd15)) dut_b (
        .clk              (clk),
        .reset_L          (reset_L),
        .start            (start_b),
        .target           (target),
        .num_entradas     (num_entradas),
        .hash_req         (hash_req_b),
        .hash_nonce       (hash_nonce_b),
        .hash_valid       (hash_valid_b),
        .hash_in          (hash_in_b),
        .fin              (fin_b),
        .exhausted        (exhausted_b),
        .nonce_valido_out (nv_b),
        .bounty_out       (bounty_b),
        .hit_count        (hits_b)
    );

    // Hash core models: fixed 3-cycle latency, not affected by DUT reset.
    logic [2:0]  vp_a = '0, vp_b = '0;
    logic [31:0] np_a0 = '0, np_a1 = '0, np_a2 = '0;
    logic [31:0] np_b0 = '0, np_b1 = '0, np_b2 = '0;
    logic        inj_a = 1'b0;
    int          req_a = 0, req_b = 0;

    always @(posedge clk) begin
        vp_a  <= {vp_a[1:0], hash_req_a === 1'b1};
        vp_b  <= {vp_b[1:0], hash_req_b === 1'b1};
        np_a0 <= hash_nonce_a; np_a1 <= np_a0; np_a2 <= np_a1;
        np_b0 <= hash_nonce_b; np_b1 <= np_b0; np_b2 <= np_b1;
        if (hash_req_a === 1'b1) req_a <= req_a + 1;
        if (hash_req_b === 1'b1) req_b <= req_b + 1;
    end

    assign hash_valid_a = vp_a[2] | inj_a;
    assign hash_valid_b = vp_b[2];
    assign hash_in_a    = {np_a2[7:0] ^ 8'hA5, 16'h0000};
    assign hash_in_b    = {np_b2[7:0] ^ 8'hA5, 16'h0000};

    typedef struct {
        logic [31:0] nonce;
        logic [23:0] bounty;
        logic [2:0]  hits;
        logic        exh;
        int          reqs;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    function automatic exp_t model(input logic [7:0] tgt, input logic [1:0] ne,
                                   input logic [31:0] maxn);
        exp_t        e;
        int          need;
        logic [31:0] nn;
        logic [7:0]  h;
        e.nonce = '0; e.bounty = '0; e.hits = '0; e.exh = 1'b0; e.reqs = 0;
        need = (ne == 2'd0) ? 4 : int'(ne);
        for (longint n = 0; n <= longint'(maxn); n++) begin
            nn = n[31:0];
            e.reqs++;
            h = nn[7:0] ^ 8'hA5;
            if (h < tgt) begin
                e.nonce  = nn;
                e.bounty = {h, 16'h0000};
                e.hits++;
                if (int'(e.hits) == need) return e;
            end
        end
        e.exh = 1'b1;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input bit sel);
        @(negedge clk);
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic finish(input bit sel, input string tag, input int base);
        bit   ok;
        exp_t e;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ((sel ? fin_b : fin_a) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        chk({tag, "_fin"}, 64'(ok), 64'd1);
        e = sb.pop_front();
        chk({tag, "_nonce"},  64'(sel ? nv_b : nv_a), 64'(e.nonce));
        chk({tag, "_bounty"}, 64'(sel ? bounty_b : bounty_a), 64'(e.bounty));
        chk({tag, "_hits"},   64'(sel ? hits_b : hits_a), 64'(e.hits));
        chk({tag, "_exh"},    64'(sel ? exhausted_b : exhausted_a), 64'(e.exh));
        chk({tag, "_reqs"},   64'((sel ? req_b : req_a) - base), 64'(e.reqs));
    endtask

    task automatic run_a(input string tag, input logic [7:0] tgt, input logic [1:0] ne);
        int base;
        target       = tgt;
        num_entradas = ne;
        sb.push_back(model(tgt, ne, 32'hFFFF_FFFF));
        base = req_a;
        pulse(1'b0);
        finish(1'b0, tag, base);
    endtask

    initial begin
        int base;
        bit got;
        reset_L = 1'b0; start_a = 1'b0; start_b = 1'b0;
        target = '0; num_entradas = '0;
        repeat (3) @(negedge clk);
        chk("rst_fin",    64'(fin_a), 64'd0);
        chk("rst_req",    64'(hash_req_a), 64'd0);
        chk("rst_nonce",  64'(hash_nonce_a), 64'd0);
        chk("rst_outs",   64'({nv_a, bounty_a, hits_a, exhausted_a}), 64'd0);
        chk("rst_b_outs", 64'({fin_b, exhausted_b, nv_b, hits_b}), 64'd0);
        reset_L = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_noreq", 64'(req_a), 64'd0);

        // T1..T3
        run_a("t1", 8'h10, 2'd1);
        run_a("t2", 8'h10, 2'd2);
        run_a("t3", 8'h10, 2'd0);

        // T4: short nonce space, unreachable target
        target = 8'h00; num_entradas = 2'd1;
        sb.push_back(model(8'h00, 2'd1, 32'd15));
        base = req_b;
        pulse(1'b1);
        finish(1'b1, "t4", base);

        // T5: restart from DONE, then reset while waiting on the third hash
        target = 8'h10; num_entradas = 2'd1;
        base = req_a;
        pulse(1'b0);
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (req_a >= base + 3) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("t5_reach_wait", 64'(got), 64'd1);
        chk("t5_pre_nv", 64'(nv_a), 64'h0000_00A3);
        #2 reset_L = 1'b0;
        #1;
        chk("t5_rst_nv",     64'(nv_a), 64'd0);
        chk("t5_rst_bounty", 64'(bounty_a), 64'd0);
        chk("t5_rst_nonce",  64'(hash_nonce_a), 64'd0);
        chk("t5_rst_flags",  64'({fin_a, exhausted_a, hash_req_a, hits_a}), 64'd0);
        @(negedge clk);
        reset_L = 1'b1;
        base = req_a;
        repeat (8) @(negedge clk);
        chk("t5_noreq",  64'(req_a - base), 64'd0);
        chk("t5_ignore", 64'({fin_a, hits_a, bounty_a}), 64'd0);

        // T6: stray hash_valid in IDLE, then restart from DONE with a start during WAIT
        @(negedge clk);
        inj_a = 1'b1;
        @(negedge clk);
        inj_a = 1'b0;
        repeat (5) @(negedge clk);
        chk("t6_stray_req", 64'(req_a - base), 64'd0);
        chk("t6_stray_st",  64'({fin_a, hits_a, nv_a}), 64'd0);
        run_a("t6a", 8'h10, 2'd1);
        sb.push_back(model(8'h10, 2'd1, 32'hFFFF_FFFF));
        base = req_a;
        pulse(1'b0);
        chk("t6_fin_drop", 64'(fin_a), 64'd0);
        chk("t6_req",      64'(hash_req_a), 64'd1);
        chk("t6_nonce0",   64'(hash_nonce_a), 64'd0);
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        finish(1'b0, "t6b", base);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
